// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// mips_defs : definitions shared by the instruction fetch stage.
//   INSTR_W       instruction word width
//   RESET_PC      boot address (must match the PC register reset value)
//   NOP_INSTR     word placed in IF/ID when empty or flushed (sll $0,$0,0)
//   fetch_state_t fetch controller state encoding
//   pc_plus4()    sequential PC with natural 32-bit wrap
// -----------------------------------------------------------------------------
package mips_defs;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_t;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if : instruction-memory request/acknowledge bus.
//   imem_req    fetch request, held until imem_ack
//   imem_addr   fetch address, stable while imem_req is high
//   imem_ack    single-cycle acknowledge, imem_rdata valid in the same cycle
//   imem_rdata  instruction word
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
   import mips_defs::*;

   logic               imem_req;
   logic [31:0]        imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ack, input  imem_rdata);
   modport slave  (input  imem_req, input  imem_addr,
                   output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_perf_counters.sv
// -----------------------------------------------------------------------------
// fetch_perf_counters : two saturating 32-bit event counters for the fetch
// stage. Counters stick at all-ones instead of wrapping.
//   clk, reset (async, active low)
//   fetch_inc  -> fetch_cnt : IF/ID loads of a valid instruction
//   stall_inc  -> stall_cnt : cycles spent waiting on memory or decode
// -----------------------------------------------------------------------------
module fetch_perf_counters (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_inc,
   input  logic        stall_inc,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);
   logic [1:0]  inc;
   logic [31:0] cnt_all [2];

   assign inc = {stall_inc, fetch_inc};

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_reg;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_reg <= '0;
         end else if (inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
            cnt_reg <= cnt_reg + 32'd1;
         end
      end

      assign cnt_all[gi] = cnt_reg;
   end

   assign fetch_cnt = cnt_all[0];
   assign stall_cnt = cnt_all[1];
endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage : instruction fetch between the PC register and decode.
// Requests current_pc from instruction memory, loads the IF/ID register and
// drives next_pc back to the PC register (which loads it every clock).
// Copes with variable memory latency, decode stalls and branch/jump
// redirects, including redirects arriving while a fetch is outstanding.
//
// Ports:
//   clk, reset (async, active low)
//   current_pc / next_pc             PC register output / input
//   imem (fetch_stage_if.master)     instruction memory req/ack bus
//   stall, flush                     hazard unit controls for IF/ID
//   branch_taken/branch_target       redirect from EX (wins over jump)
//   jump/jump_target                 redirect from ID
//   ifid_valid/ifid_instr/ifid_pc4   IF/ID register
//   perf_fetch_cnt/perf_stall_cnt    only when FETCH_PERF_EN is defined
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = mips_defs::RESET_PC,
   parameter logic [31:0] NOP_INSTR = mips_defs::NOP_INSTR
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [31:0]                   current_pc,
   output logic [31:0]                   next_pc,
   fetch_stage_if.master                 imem,
   input  logic                          stall,
   input  logic                          flush,
   input  logic                          branch_taken,
   input  logic [31:0]                   branch_target,
   input  logic                          jump,
   input  logic [31:0]                   jump_target,
   output logic                          ifid_valid,
   output logic [mips_defs::INSTR_W-1:0] ifid_instr,
   output logic [31:0]                   ifid_pc4
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]                   perf_fetch_cnt,
   output logic [31:0]                   perf_stall_cnt
`endif
);
   import mips_defs::*;

   fetch_state_t       state_reg, state_next;
   logic [INSTR_W-1:0] hold_buf_reg, hold_buf_next;
   logic [31:0]        redir_tgt_reg, redir_tgt_next;

   logic               ifid_valid_reg;
   logic [INSTR_W-1:0] ifid_instr_reg;
   logic [31:0]        ifid_pc4_reg;

   logic               redirect;
   logic [31:0]        redirect_target;
   logic [31:0]        pc_seq;
   logic               load;
   logic [INSTR_W-1:0] load_instr;
   logic               kill;

   assign redirect        = branch_taken | jump;
   assign redirect_target = branch_taken ? branch_target : jump_target;
   assign pc_seq          = pc_plus4(current_pc);

   // Decoded straight from the state register so the request drops the
   // instant reset is asserted.
   assign imem.imem_req  = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
   assign imem.imem_addr = current_pc;

   always_comb begin
      state_next     = state_reg;
      hold_buf_next  = hold_buf_reg;
      redir_tgt_next = redir_tgt_reg;
      next_pc        = current_pc;
      load           = 1'b0;
      load_instr     = imem.imem_rdata;
      kill           = 1'b0;

      case (state_reg)
         S_IDLE: begin
            state_next = S_FETCH;
         end

         S_FETCH: begin
            if (imem.imem_ack) begin
               if (redirect) begin
                  // Wrong-path word: drop it and refetch from the target.
                  next_pc = redirect_target;
                  kill    = 1'b1;
               end else if (stall) begin
                  hold_buf_next = imem.imem_rdata;
                  state_next    = S_HOLD;
               end else begin
                  load    = 1'b1;
                  next_pc = pc_seq;
               end
            end else if (redirect) begin
               // Cannot abandon the in-flight request; remember where to go.
               redir_tgt_next = redirect_target;
               kill           = 1'b1;
               state_next     = S_DRAIN;
            end
         end

         S_HOLD: begin
            if (redirect) begin
               next_pc    = redirect_target;
               kill       = 1'b1;
               state_next = S_FETCH;
            end else if (!stall) begin
               load       = 1'b1;
               load_instr = hold_buf_reg;
               next_pc    = pc_seq;
               state_next = S_FETCH;
            end
         end

         S_DRAIN: begin
            if (redirect) begin
               redir_tgt_next = redirect_target;
               kill           = 1'b1;
            end
            if (imem.imem_ack) begin
               // Latest redirect wins, including one arriving with the ack.
               next_pc    = redirect ? redirect_target : redir_tgt_reg;
               state_next = S_FETCH;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         hold_buf_reg  <= '0;
         // Always rewritten before use; boot address is just a benign value.
         redir_tgt_reg <= RESET_PC;
      end else begin
         state_reg     <= state_next;
         hold_buf_reg  <= hold_buf_next;
         redir_tgt_reg <= redir_tgt_next;
      end
   end

   // IF/ID: flush beats stall, stall beats load/kill.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ifid_valid_reg <= 1'b0;
         ifid_instr_reg <= NOP_INSTR;
         ifid_pc4_reg   <= '0;
      end else if (flush) begin
         ifid_valid_reg <= 1'b0;
         ifid_instr_reg <= NOP_INSTR;
      end else if (!stall) begin
         if (load) begin
            ifid_valid_reg <= 1'b1;
            ifid_instr_reg <= load_instr;
            ifid_pc4_reg   <= pc_seq;
         end else if (kill) begin
            ifid_valid_reg <= 1'b0;
         end
      end
   end

   assign ifid_valid = ifid_valid_reg;
   assign ifid_instr = ifid_instr_reg;
   assign ifid_pc4   = ifid_pc4_reg;

`ifdef FETCH_PERF_EN
   fetch_perf_counters u_perf (
      .clk       (clk),
      .reset     (reset),
      .fetch_inc (load && !flush),
      .stall_inc ((state_reg == S_HOLD) ||
                  ((state_reg == S_FETCH) && !imem.imem_ack)),
      .fetch_cnt (perf_fetch_cnt),
      .stall_cnt (perf_stall_cnt)
   );
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly downstream of the program-counter register and upstream of decode.
- Consumes current_pc and requests the instruction from instruction memory over a req/ack handshake.
- Captures the result into the IF/ID register and drives next_pc back to the PC register.
- Handles variable memory latency, decode stalls, and branch/jump redirects, including redirects that arrive while a fetch is outstanding.

Parameters:
RESET_PC, 32'h00000000, boot address; must match the PC register reset value.
NOP_INSTR, 32'h00000000, instruction word placed in IF/ID when it is empty or flushed (sll $0,$0,0).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
current_pc  in  32  PC register output.
next_pc  out  32  PC register input; the PC loads it every clock.
imem_req  out  1  fetch request; held high until imem_ack.
imem_addr  out  32  fetch address; stable while imem_req is high.
imem_ack  in  1  single-cycle acknowledge; imem_rdata valid in the same cycle.
imem_rdata  in  32  instruction word.
stall  in  1  hazard unit: decode cannot accept a new IF/ID entry.
flush  in  1  invalidate IF/ID (control hazard).
branch_taken  in  1  redirect request from EX.
branch_target  in  32  branch destination.
jump  in  1  redirect request from ID.
jump_target  in  32  jump destination.
ifid_valid  out  1  IF/ID holds a real instruction.
ifid_instr  out  32  IF/ID instruction.
ifid_pc4  out  32  IF/ID fetch address + 4.

Behaviour:
- Reset (reset=0): state=S_IDLE, imem_req=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc4=0, redirect register cleared.
- next_pc = current_pc (hold) unless stated otherwise; PC+4 uses 32-bit wrap (0xFFFFFFFC -> 0x00000000).
- Redirect target selection: branch_taken has priority over jump.
- imem_req = 1 in S_FETCH and S_DRAIN; imem_addr = current_pc in both states.
- S_IDLE: one cycle after reset release, then go to S_FETCH.
- S_FETCH, imem_ack=0, redirect present: latch target, go to S_DRAIN.
- S_FETCH, imem_ack=0, no redirect: stay.
- S_FETCH, imem_ack=1, redirect present:
  - discard rdata; next_pc = target; stay in S_FETCH.
  - ifid_valid = 0.
- S_FETCH, imem_ack=1, stall=1: store rdata in hold buffer, go to S_HOLD.
- S_FETCH, imem_ack=1, otherwise:
  - IF/ID <= {1, rdata, current_pc+4}; next_pc = current_pc+4.
  - Fetch latency is therefore ack cycle + 1 clock to ifid_valid.
- S_HOLD: imem_req=0.
  - Redirect: drop the buffer, next_pc = target, go to S_FETCH.
  - stall=0: IF/ID <= buffer, next_pc = current_pc+4, go to S_FETCH.
- S_DRAIN: old request still outstanding.
  - New redirect overwrites the latched target (latest wins).
  - On imem_ack: discard rdata, next_pc = latched target, go to S_FETCH.
- IF/ID register updates:
  - stall=1: IF/ID holds its contents.
  - flush=1: ifid_valid <= 0, ifid_instr <= NOP_INSTR; flush beats both stall and load.
  - Redirect with no accepted load: ifid_valid <= 0.
- Reset mid-fetch: imem_req drops asynchronously; any pending ack after release is ignored in S_IDLE.

Optional Feature:
Macro: FETCH_PERF_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both saturating at 0xFFFFFFFF and reset to 0.
  - perf_fetch_cnt: +1 per IF/ID load with valid=1.
  - perf_stall_cnt: +1 per cycle in S_HOLD or S_FETCH with imem_ack=0.
- Undefined: counters and ports absent; all other behaviour identical.

Decomposition:
- Shared package mips_defs holds:
  - RESET_PC and NOP_INSTR constants.
  - Fetch state encoding: S_IDLE=2'd0, S_FETCH=2'd1, S_HOLD=2'd2, S_DRAIN=2'd3.
  - The instruction word width constant.
- Sub-module fetch_perf_counters contains the two saturating counters, instantiated only under FETCH_PERF_EN.
- FSM, hold buffer and IF/ID register stay in fetch_stage.

Test Plan:
- Reset release, PC=0, memory acks after 2 cycles with 0x20080005 -> imem_req rises 1 cycle after release; ifid_valid=1, ifid_instr=0x20080005, ifid_pc4=0x4 one clock after ack; next_pc=0x4 in the ack cycle.
- Ack with stall=1 held for 3 cycles -> S_HOLD, imem_req=0, IF/ID unchanged; on stall=0, IF/ID loads the buffered word and PC advances by exactly 4.
- branch_taken with target 0x40 while a fetch at 0x10 is pending (no ack) -> imem_addr stays 0x10 until ack; rdata discarded; next_pc=0x40; next request at 0x40; ifid_valid=0.
- branch_taken and jump asserted together (0x80 vs 0xC0) in an ack cycle -> next_pc=0x80.
- flush and ack with stall=0 in the same cycle -> ifid_valid=0, ifid_instr=NOP_INSTR; PC still advances.
- FETCH_PERF_EN: 10 fetches with 1-cycle ack latency -> perf_fetch_cnt=10, perf_stall_cnt=10; reset mid-run clears both and drops imem_req immediately.
